// File: rtl/eth_pt_frame_fwd_if.sv
`default_nettype none
// ============================================================================
// Interface : eth_pt_frame_fwd_if
// Purpose   : Avalon-ST RX sink and TX source bundles of the passthrough frame
//             forwarder.
//   in_*  : beats coming from the TSE port A RX FIFO (data, valid, sop, eop,
//           empty, error) plus the in_ready returned to it
//   out_* : beats going to the TSE port B TX FIFO (data, valid, sop, eop,
//           empty, error) plus the out_ready coming back from it
// Modports  : master = the environment driving RX and consuming TX
//             slave  = the frame forwarder itself
// Revision  : 1.0 - initial release
// ============================================================================
interface eth_pt_frame_fwd_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_sop;
  logic        in_eop;
  logic [1:0]  in_empty;
  logic [5:0]  in_error;

  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  out_empty;
  logic        out_error;

  modport master (
    output in_data, in_valid, in_sop, in_eop, in_empty, in_error, out_ready,
    input  in_ready, out_data, out_valid, out_sop, out_eop, out_empty, out_error
  );

  modport slave (
    input  in_data, in_valid, in_sop, in_eop, in_empty, in_error, out_ready,
    output in_ready, out_data, out_valid, out_sop, out_eop, out_empty, out_error
  );
endinterface
`default_nettype wire

// File: rtl/eth_pt_frame_fwd.sv
`default_nettype none
// ============================================================================
// Module    : eth_pt_frame_fwd
// Purpose   : Store-and-forward frame buffer between TSE port A RX and TSE
//             port B TX. A frame is only released to TX once it has been
//             received completely and ended without error; errored,
//             truncated (sop before eop) and overflowing frames are dropped.
// Ports     : clk_clk      - system clock
//             reset_reset  - synchronous active-high reset
//             st           - RX sink / TX source bundle (slave modport)
//             cnt_fwd      - frames fully sent on TX
//             cnt_drop_err - frames dropped for error or missing eop
//             cnt_drop_ovf - frames dropped for buffer overflow
//             level        - words held (committed + in-progress)
// Revision  : 1.0 - initial release
// ============================================================================
module eth_pt_frame_fwd #(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 32
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  eth_pt_frame_fwd_if.slave st,
  output logic [CNT_W-1:0]  cnt_fwd,
  output logic [CNT_W-1:0]  cnt_drop_err,
  output logic [CNT_W-1:0]  cnt_drop_ovf,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] c_depth   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] c_ptr_one = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_DROP  = 2'd2
  } wr_state_t;

  // Word layout: {eop, empty[1:0], data[31:0]}
  logic [34:0]      r_mem [2**ADDR_W];

  wr_state_t        r_state;
  wr_state_t        w_state_nxt;
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_commit_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic [ADDR_W:0]  r_frames_avail;
  logic [CNT_W-1:0] r_cnt_fwd;
  logic [CNT_W-1:0] r_cnt_drop_err;
  logic [CNT_W-1:0] r_cnt_drop_ovf;

  logic [ADDR_W:0]  w_wr_ptr_nxt;
  logic [ADDR_W:0]  w_base;
  logic [ADDR_W:0]  w_free;
  logic             w_commit;
  logic             w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [1:0]       w_err_inc;
  logic             w_ovf_inc;

  // Read pipeline: stage 1 is the synchronous memory read, stage 2 the
  // output register presented on TX.
  logic             r_s1_valid;
  logic [34:0]      r_s1_word;
  logic             r_out_valid;
  logic             r_out_sop;
  logic             r_out_eop;
  logic [1:0]       r_out_empty;
  logic [31:0]      r_out_data;
  logic             r_first;

  logic             w_can_read;
  logic             w_out_load;
  logic             w_s1_adv;
  logic             w_rd_en;
  logic             w_eop_hs;

  // --------------------------------------------------------------------------
  // Write side: next-state and pointer decisions
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_base       = r_wr_ptr;
    w_free       = c_depth - (r_wr_ptr - r_rd_ptr);
    w_commit     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = r_wr_ptr[ADDR_W-1:0];
    w_err_inc    = 2'd0;
    w_ovf_inc    = 1'b0;

    if (st.in_valid) begin
      if (st.in_sop || (r_state == S_STORE)) begin
        // A sop always opens a new frame at the commit point; if a frame was
        // still open its words are abandoned and it counts as an error drop.
        if (st.in_sop) begin
          w_base = r_commit_ptr;
          if (r_state == S_STORE) begin
            w_err_inc = 2'd1;
          end
        end
        w_free = c_depth - (w_base - r_rd_ptr);

        if (w_free == '0) begin
          w_wr_ptr_nxt = r_commit_ptr;
          w_ovf_inc    = 1'b1;
          w_state_nxt  = st.in_eop ? S_IDLE : S_DROP;
        end else if (st.in_eop && (st.in_error != 6'd0)) begin
          w_wr_ptr_nxt = r_commit_ptr;
          w_err_inc    = w_err_inc + 2'd1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_mem_we     = 1'b1;
          w_mem_addr   = w_base[ADDR_W-1:0];
          w_wr_ptr_nxt = w_base + c_ptr_one;
          if (st.in_eop) begin
            w_commit    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_STORE;
          end
        end
      end else if ((r_state == S_DROP) && st.in_eop) begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Read side control
  // --------------------------------------------------------------------------
  // rd_ptr never passes commit_ptr, so rewound words are never fetched.
  assign w_can_read = (r_frames_avail != '0) && (r_rd_ptr != r_commit_ptr);
  assign w_out_load = !r_out_valid || st.out_ready;
  assign w_s1_adv   = r_s1_valid && w_out_load;
  assign w_rd_en    = w_can_read && (!r_s1_valid || w_s1_adv);
  assign w_eop_hs   = r_out_valid && st.out_ready && r_out_eop;

  // --------------------------------------------------------------------------
  // Buffer memory (no reset: contents are qualified by the pointers).
  // A write never targets the word being read: writes land at or beyond
  // commit_ptr, reads strictly below it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= {st.in_eop, st.in_empty, st.in_data};
    end
    if (w_rd_en) begin
      r_s1_word <= r_mem[r_rd_ptr[ADDR_W-1:0]];
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, frame count and statistics
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_wr_ptr       <= '0;
      r_commit_ptr   <= '0;
      r_rd_ptr       <= '0;
      r_frames_avail <= '0;
      r_cnt_fwd      <= '0;
      r_cnt_drop_err <= '0;
      r_cnt_drop_ovf <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      if (w_commit) begin
        r_commit_ptr <= w_wr_ptr_nxt;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_commit && !w_eop_hs) begin
        r_frames_avail <= r_frames_avail + c_ptr_one;
      end else if (!w_commit && w_eop_hs) begin
        r_frames_avail <= r_frames_avail - c_ptr_one;
      end
      if (w_eop_hs) begin
        r_cnt_fwd <= r_cnt_fwd + CNT_W'(1);
      end
      r_cnt_drop_err <= r_cnt_drop_err + CNT_W'(w_err_inc);
      if (w_ovf_inc) begin
        r_cnt_drop_ovf <= r_cnt_drop_ovf + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_empty <= 2'd0;
      r_out_data  <= 32'd0;
      r_first     <= 1'b1;
    end else begin
      if (w_rd_en) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      // Output register only moves when empty or being accepted, so it holds
      // steady under backpressure.
      if (w_out_load) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_eop   <= r_s1_word[34];
          r_out_empty <= r_s1_word[33:32];
          r_out_data  <= r_s1_word[31:0];
          r_out_sop   <= r_first;
          // The beat after an eop starts the next frame.
          r_first     <= r_s1_word[34];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign st.in_ready   = !reset_reset;
  assign st.out_valid  = r_out_valid;
  assign st.out_sop    = r_out_sop;
  assign st.out_eop    = r_out_eop;
  assign st.out_empty  = r_out_empty;
  assign st.out_data   = r_out_data;
  assign st.out_error  = 1'b0;

  assign cnt_fwd      = r_cnt_fwd;
  assign cnt_drop_err = r_cnt_drop_err;
  assign cnt_drop_ovf = r_cnt_drop_ovf;
  assign level        = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire
